// File: rtl/rv32_mmio_uart_tx_if.sv
// Shared bus types plus the MMIO slot interface (core request in, done/read data out).
package rv32_mmio_uart_tx_pkg;
  typedef logic [31:0] rv32_word;
  typedef enum logic [1:0] {MEM_NONE, MEM_READ, MEM_WRITE} mem_op_e;
  typedef struct packed {
    rv32_word addr;
    rv32_word data;
    mem_op_e  op;
  } memory_request_t;
endpackage

interface rv32_mmio_uart_tx_if;
  import rv32_mmio_uart_tx_pkg::*;
  memory_request_t data_request;
  logic            request_done;
  rv32_word        read_data;

  modport master (output data_request, input request_done, input read_data);
  modport slave  (input data_request, output request_done, output read_data);
endinterface

// File: rtl/rv32_mmio_uart_tx.sv
// MMIO UART transmitter: 4-register window, TX FIFO, 8N1 shifter with per-frame divisor latch.
module rv32_mmio_uart_tx
  import rv32_mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic                 clk,
  input  logic                 resetn,
  rv32_mmio_uart_tx_if.slave   mmio,
  output logic                 uart_tx,
  output logic                 tx_idle
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              STAGES   = 1;
  localparam logic [AW:0]     LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---- bus decode ----
  logic       hit, wr, push_req, div_wr, ovf_clr;
  logic [1:0] off;
  logic       unused_bits;

  assign hit      = (mmio.data_request.op == MEM_READ || mmio.data_request.op == MEM_WRITE)
                 && (mmio.data_request.addr[31:4] == BASE_ADDR[31:4]);
  assign wr       = hit && (mmio.data_request.op == MEM_WRITE);
  assign off      = mmio.data_request.addr[3:2];
  assign push_req = wr && (off == 2'd0);
  assign div_wr   = wr && (off == 2'd2);
  assign ovf_clr  = wr && (off == 2'd1) && mmio.data_request.data[3];
  assign unused_bits = ^{mmio.data_request.addr[1:0], mmio.data_request.data[31:16]};

  // ---- response pipeline: done one cycle after the hit, data one cycle later ----
  logic [STAGES:0] vld_pipe;
  logic            rd_q;
  logic [1:0]      off_q;
  logic [15:0]     divisor;
  logic            overflow;
  logic [AW:0]     level;
  logic            full, empty, busy, pop, accept;
  logic [31:0]     status_word;
  state_e          state, state_d;

  assign vld_pipe[0] = hit;
  assign mmio.request_done = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_pipe[STAGES:1] <= '0;
      rd_q               <= 1'b0;
      off_q              <= 2'd0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      rd_q               <= hit && (mmio.data_request.op == MEM_READ);
      off_q              <= off;
    end
  end

  assign full        = (level == LVL_FULL);
  assign empty       = (level == '0);
  assign busy        = (state != S_IDLE);
  assign status_word = {16'h0, 8'(level), 4'h0, overflow, busy, empty, full};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mmio.read_data <= '0;
    end else if (vld_pipe[STAGES] && rd_q) begin
      case (off_q)
        2'd1:    mmio.read_data <= status_word;
        2'd2:    mmio.read_data <= {16'h0, divisor};
        default: mmio.read_data <= '0;
      endcase
    end
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      divisor  <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (div_wr) divisor <= mmio.data_request.data[15:0];
      if (ovf_clr) overflow <= 1'b0;
      else if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // ---- TX FIFO; a same-cycle pop frees the slot for a write to a full FIFO ----
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign accept = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= mmio.data_request.data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase
    end
  end

  // ---- shifter ----
  logic [15:0] cnt, cnt_d, div_lat, div_lat_d;
  logic [2:0]  bit_idx, bit_d;
  logic [7:0]  shreg, sh_d;
  logic        tx_q, tx_d, load;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_lat <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      div_lat <= div_lat_d;
      bit_idx <= bit_d;
      shreg   <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line value for the next cycle, so uart_tx comes straight from tx_q.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    div_lat_d = div_lat;
    bit_d     = bit_idx;
    sh_d      = shreg;
    tx_d      = tx_q;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      S_START: begin
        tx_d = 1'b0;
        if (cnt == '0) begin
          state_d = S_DATA;
          cnt_d   = div_lat;
          bit_d   = 3'd0;
          tx_d    = shreg[0];
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_d = div_lat;
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_idx + 3'd1;
            sh_d  = {1'b0, shreg[7:1]};
            tx_d  = shreg[1];
          end
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt == '0) begin
          if (!empty) load = 1'b1;
          else        state_d = S_IDLE;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      pop       = 1'b1;
      sh_d      = fifo_mem[rd_ptr];
      div_lat_d = divisor;
      cnt_d     = divisor;
      state_d   = S_START;
      tx_d      = 1'b0;
    end
  end

  assign uart_tx = tx_q;
  assign tx_idle = empty && (state == S_IDLE);
endmodule

// File: tb/tb_rv32_mmio_uart_tx.sv
// Bench for rv32_mmio_uart_tx: bus scoreboard plus a serial-line frame decoder.
module tb_rv32_mmio_uart_tx;
  import rv32_mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam logic [15:0] DEF   = 16'd433;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_tx, tx_idle;

  rv32_mmio_uart_tx_if mmio_if();

  rv32_mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .resetn(resetn), .mmio(mmio_if), .uart_tx(uart_tx), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---- reference model state ----
  typedef struct { bit rd; logic [31:0] exp; } sb_t;
  sb_t         sbq[$];
  logic [7:0]  expq[$];
  int          mcnt = 0;
  logic [15:0] mdiv = DEF;
  logic [15:0] div_eff, div_prev;
  int          wr_cyc = 0, last_start = 0;

  function automatic bit is_hit(input mem_op_e op, input logic [31:0] a);
    return (op == MEM_READ || op == MEM_WRITE) && (a[31:4] == BASE[31:4]);
  endfunction

  function automatic logic [31:0] stat(input int lvl, input bit busy, input bit ovf);
    return {16'h0, 8'(lvl), 4'h0, ovf, busy, lvl == 0, lvl == DEPTH};
  endfunction

  // divisor in force during the previous cycle == the one latched by a pop in that cycle
  always @(posedge clk) begin
    if (!resetn) begin
      div_eff  <= DEF;
      div_prev <= DEF;
    end else begin
      div_prev <= div_eff;
      if (mmio_if.data_request.op == MEM_WRITE && is_hit(MEM_WRITE, mmio_if.data_request.addr)
          && mmio_if.data_request.addr[3:2] == 2'd2)
        div_eff <= mmio_if.data_request.data[15:0];
    end
  end

  // ---- bus monitor / scoreboard ----
  bit          pend = 0;
  logic [31:0] pend_exp;
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      pend = 0;
      sbq.delete();
    end else begin
      if (pend) begin
        check("read_data", mmio_if.read_data, pend_exp);
        pend = 0;
      end
      if (mmio_if.request_done) begin
        if (sbq.size() == 0) check("spurious_done", {31'h0, mmio_if.request_done}, 32'h0);
        else begin
          sb_t e;
          e = sbq.pop_front();
          if (e.rd) begin pend = 1; pend_exp = e.exp; end
        end
      end
    end
  end

  // ---- line monitor: decode each frame with the divisor it should have latched ----
  initial begin : line_mon
    int d, len, bad, k;
    logic [7:0] b, rx;
    logic expb;
    bit abort;
    forever begin
      @(negedge clk);
      if (resetn && uart_tx === 1'b0) begin
        if (expq.size() == 0) check("unexpected_start", {31'h0, uart_tx}, 32'h1);
        else begin
          b = expq.pop_front(); mcnt--;
          d = int'(div_prev); len = 10 * (d + 1);
          bad = 0; rx = 8'h0; abort = 0; last_start = cyc;
          for (int i = 1; i < len; i++) begin
            @(negedge clk);
            if (!resetn) begin abort = 1; break; end
            k = i / (d + 1);
            expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            if (uart_tx !== expb) bad++;
            if (k >= 1 && k <= 8 && (i % (d + 1)) == (d + 1) / 2) rx[k-1] = uart_tx;
          end
          if (!abort) begin
            check("frame_byte", {24'h0, rx}, {24'h0, b});
            check("frame_timing", 32'(bad), 32'h0);
          end
        end
      end
    end
  end

  // ---- stimulus ----
  task automatic bus(input mem_op_e op, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp);
    @(posedge clk); #1;
    mmio_if.data_request = '{addr: a, data: d, op: op};
    if (is_hit(op, a)) begin
      sbq.push_back('{rd: (op == MEM_READ), exp: exp});
      if (op == MEM_WRITE && a[3:2] == 2'd0) begin
        if (mcnt < DEPTH) begin expq.push_back(d[7:0]); mcnt++; end
        wr_cyc = cyc;
      end
      if (op == MEM_WRITE && a[3:2] == 2'd2) mdiv = d[15:0];
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mmio_if.data_request = '{addr: 32'h0, data: 32'h0, op: MEM_NONE};
  endtask

  task automatic wait_idle(input int max);
    int n;
    idle();
    n = 0;
    while (n < max && !(tx_idle && expq.size() == 0)) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("tx_idle", {31'h0, tx_idle}, 32'h1);
    check("frames_drained", 32'(expq.size()), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    mmio_if.data_request = '{addr: 32'h0, data: 32'h0, op: MEM_NONE};
    expq.delete(); mcnt = 0; mdiv = DEF;
    @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_tx_idle", {31'h0, tx_idle}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, sel;
    logic [31:0] a, d;
    mmio_if.data_request = '{addr: 32'h0, data: 32'h0, op: MEM_NONE};
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'h0, mmio_if.request_done}, 32'h0);
    check("rst_read_data", mmio_if.read_data, 32'h0);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_tx_idle", {31'h0, tx_idle}, 32'h1);
    @(posedge clk); #1 resetn = 1'b1;

    // reset register contents
    bus(MEM_READ, BASE + 32'h4, 32'h0, stat(0, 0, 0));
    bus(MEM_READ, BASE + 32'h8, 32'h0, {16'h0, DEF});
    bus(MEM_READ, BASE + 32'hC, 32'h0, 32'h0);
    bus(MEM_READ, BASE + 32'h0, 32'h0, 32'h0);

    // single 0x55 frame at DIVISOR=3, start bit two cycles after the write
    bus(MEM_WRITE, BASE + 32'h8, 32'd3, 32'h0);
    bus(MEM_WRITE, BASE + 32'h0, 32'h55, 32'h0);
    wait_idle(200);
    check("start_latency", 32'(last_start - wr_cyc), 32'd2);

    // nine back-to-back pushes at DIVISOR=0 fit because the first is popped
    bus(MEM_WRITE, BASE + 32'h8, 32'd0, 32'h0);
    for (int i = 0; i < 9; i++) bus(MEM_WRITE, BASE, $urandom, 32'h0);
    wait_idle(500);
    bus(MEM_READ, BASE + 32'h4, 32'h0, stat(0, 0, 0));

    // ten pushes at DIVISOR=100: one dropped, overflow sticky until cleared
    bus(MEM_WRITE, BASE + 32'h8, 32'd100, 32'h0);
    for (int i = 0; i < 10; i++) bus(MEM_WRITE, BASE, $urandom, 32'h0);
    bus(MEM_READ,  BASE + 32'h4, 32'h0, stat(8, 1, 1));
    bus(MEM_WRITE, BASE + 32'h4, 32'h8, 32'h0);
    bus(MEM_READ,  BASE + 32'h4, 32'h0, stat(8, 1, 0));
    bus(MEM_READ,  BASE + 32'h8, 32'h0, 32'd100);
    idle();

    // reset during the data bits of the first frame
    repeat (150) @(posedge clk);
    do_reset();
    bus(MEM_READ, BASE + 32'h4, 32'h0, stat(0, 0, 0));
    bus(MEM_READ, BASE + 32'h8, 32'h0, {16'h0, DEF});

    // divisor change mid-frame applies to the following frame only
    bus(MEM_WRITE, BASE + 32'h8, 32'd3, 32'h0);
    bus(MEM_WRITE, BASE, 32'hA5, 32'h0);
    bus(MEM_WRITE, BASE, 32'h3C, 32'h0);
    idle();
    repeat (10) @(posedge clk);
    bus(MEM_WRITE, BASE + 32'h8, 32'd7, 32'h0);
    wait_idle(300);

    // misses and non-ops: no done, no side effects
    bus(MEM_WRITE, BASE + 32'h10, 32'hAA, 32'h0);
    bus(MEM_WRITE, 32'h0FFF_FFF8, 32'h5, 32'h0);
    bus(MEM_READ,  32'h0FFF_FFF0, 32'h0, 32'h0);
    bus(MEM_NONE,  BASE + 32'h8, 32'h9, 32'h0);
    bus(MEM_WRITE, BASE + 32'hC, 32'hFFFF_FFFF, 32'h0);
    idle();
    repeat (20) @(posedge clk);
    bus(MEM_READ, BASE + 32'h8, 32'h0, 32'd7);
    bus(MEM_READ, BASE + 32'h4, 32'h0, stat(0, 0, 0));
    bus(MEM_READ, BASE + 32'hC, 32'h0, 32'h0);

    // random register traffic, back-to-back
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      d = $urandom;
      case (sel)
        0: bus(MEM_READ,  BASE + 32'h8, 32'h0, {16'h0, mdiv});
        1: bus(MEM_WRITE, BASE + 32'h8, d, 32'h0);
        2: bus(MEM_READ,  BASE + 32'h4, 32'h0, stat(0, 0, 0));
        3: bus($urandom_range(0, 1) ? MEM_READ : MEM_WRITE, BASE + 32'hC, d, 32'h0);
        4: bus(MEM_READ,  BASE + 32'h0 + 32'($urandom_range(0, 3)), 32'h0, 32'h0);
        5: begin
          a = $urandom;
          if (a[31:4] == BASE[31:4]) a = a ^ 32'h10;
          bus($urandom_range(0, 1) ? MEM_READ : MEM_WRITE, a, d, 32'h0);
        end
        6: bus(MEM_WRITE, BASE + 32'h4, d, 32'h0);
        default: bus(MEM_NONE, BASE + 32'($urandom_range(0, 15)), d, 32'h0);
      endcase
    end
    bus(MEM_READ, BASE + 32'h8, 32'h0, {16'h0, mdiv});

    // random short bursts of frames
    for (int r = 0; r < 3; r++) begin
      bus(MEM_WRITE, BASE + 32'h8, 32'($urandom_range(0, 3)), 32'h0);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) bus(MEM_WRITE, BASE, $urandom, 32'h0);
      wait_idle(400);
    end

    idle();
    repeat (5) @(negedge clk);
    check("missing_done", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rv32_mmio_uart_tx.md
# rv32_mmio_uart_tx

Memory-mapped UART transmitter that plugs into one slot of the top-level MMIO bus, alongside the other MMIO devices. It decodes the core's data request, answers with a one-cycle done pulse plus registered read data, and serializes bytes from an internal FIFO onto `uart_tx` in 8N1 format. It is the device feeding one `mmio_request_done[i]`/`mmio_data[i]` pair.

## Interface
- `BASE_ADDR`, 32'h1000_0000, word-aligned base of the 16-byte register window
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, >= 2
- `DEFAULT_DIV`, 16'd433, reset value of DIVISOR (bit period = DIVISOR+1 clocks)

- `clk` in 1, clock
- `resetn` in 1, reset: synchronous, active-low
- `data_request` in memory_request_t, core data request; uses `addr`, `data`, and the read/write/none op
- `request_done` out 1, one-cycle pulse acknowledging a request to this window
- `read_data` out rv32_word, registered read result
- `uart_tx` out 1, serial line, idle high
- `tx_idle` out 1, high when FIFO empty and shifter idle

## Operation
- Register map (offset from BASE_ADDR, addr[3:2]; addr[1:0] ignored):
  - 0x0 TXDATA: write pushes `data[7:0]`; read returns 0
  - 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (shifter not IDLE), bit3 overflow (sticky), bits[15:8] FIFO level, rest 0; write with data[3]=1 clears overflow, other bits ignored
  - 0x8 DIVISOR: r/w, bits[15:0]; upper bits read 0
  - 0xC: reserved; read 0, write ignored, still acknowledged
- Hit: op is read or write and addr[31:4] == BASE_ADDR[31:4]. Misses produce no response and no side effects.
- Write to TXDATA when full: byte dropped, overflow set. If the shifter pops in the same cycle, the write is accepted; level is unchanged and overflow is not set.
- Shifter FSM IDLE -> START -> DATA -> STOP -> IDLE (or -> START if FIFO non-empty).
  - IDLE with FIFO non-empty: pop head into shift register, latch DIVISOR, go to START.
  - START drives 0; DATA drives 8 bits LSB first; STOP drives 1. Each lasts latched DIVISOR+1 clocks.
  - From STOP, back-to-back frames pop directly with no extra idle cycle.
- A DIVISOR write during a frame takes effect at the next frame's start.
- `uart_tx` is driven from a flop (no combinational path).
- Level counter is log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `request_done`=0, `read_data`=0, `uart_tx`=1, `tx_idle`=1, FIFO empty, overflow=0, DIVISOR=DEFAULT_DIV, FSM=IDLE.
- Hit in cycle N:
  - `request_done`=1 in cycle N+1 only.
  - For reads, `read_data` is updated at the end of N+1 and valid from N+2 until the next hit read. This matches the bus controller's registered selector.
  - Writes take effect at the end of N; STATUS read in N+1 reflects them.
- A hit every cycle produces a done every cycle; no back-pressure.
- First start-bit edge on `uart_tx` appears 2 cycles after the TXDATA write cycle (push, then pop and drive). Frame length is 10*(DIVISOR+1) clocks.
- Reset asserted mid-frame: next cycle `uart_tx`=1, FIFO flushed, partial frame abandoned.

## Test plan
- Reset, then read STATUS at BASE+4 -> done one cycle later; read_data = 32'h0000_0002 (empty); `uart_tx`=1.
- DIVISOR=3, write 0x55 to TXDATA -> line shows 0 for 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then 1 for 4 clocks. Total 40 clocks; `tx_idle` returns to 1.
- DIVISOR=0, push 9 bytes back-to-back with FIFO_DEPTH=8 while the shifter drains -> no overflow (first byte popped). Push 10 more with DIVISOR=100 -> STATUS bit3=1, level=8; write 0x8 to STATUS -> bit3=0.
- Write DIVISOR=7 mid-frame at DIVISOR=3 -> current frame keeps 4-clock bits; next frame uses 8-clock bits.
- Requests to BASE+0x10 and 0x0FFF_FFF0 -> no `request_done`, state unchanged. Read of 0xC -> done, read_data=0.
- Assert resetn=0 during the DATA state -> `uart_tx`=1 next cycle; STATUS reads 0x2 and DIVISOR reads DEFAULT_DIV after release.
